// File: rtl/vote_tally_n.sv
// Ballot tally unit: saturating per-candidate and total counts, a sequential
// winner/tie scan after the polls close, and a steppable result display.
module vote_tally_n #(
   parameter int N_CAND = 15,
   parameter int CNT_W  = 12,
   parameter int IDX_W  = 4
) (
   input  logic             clk,
   input  logic             Power_n,
   input  logic             Clear,
   input  logic             Close,
   input  logic             Ballot,
   input  logic             Total,
   input  logic             Result,
   input  logic [IDX_W-1:0] IN,
   output logic [CNT_W-1:0] out,
   output logic [IDX_W-1:0] out_idx,
   output logic             ready,
   output logic             busy,
   output logic             reject,
   output logic [IDX_W-1:0] winner,
   output logic             tie,
   output logic             win_valid
);

   typedef enum logic [2:0] {IDLE, ARMED, TOTAL, SCAN, RESULT, CLR} state_t;

   localparam logic [IDX_W-1:0] LAST    = IDX_W'(N_CAND);
   localparam logic [IDX_W-1:0] FIRST   = IDX_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] tally [1:N_CAND];
   logic [CNT_W-1:0] total, max_val, scan_val, res_val, out_nxt;
   logic [IDX_W-1:0] scan_k, clr_k, win_fin, out_idx_nxt;
   logic             closed, result_prev, result_rise;
   logic             in_valid, in_high, vote, start_scan, start_clr;
   logic             scan_gt, scan_eq;

   assign in_valid    = (IN != '0) && (IN <= LAST);
   assign in_high     = IN > LAST;
   assign result_rise = Result & ~result_prev;
   assign ready       = (state == ARMED);
   assign busy        = (state == SCAN) || (state == CLR);

   always_ff @(posedge clk or negedge Power_n) begin
      if (!Power_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Command decode; Clear always wins except while CLR is already running.
   always_comb begin
      state_nxt  = state;
      vote       = 1'b0;
      start_scan = 1'b0;
      start_clr  = 1'b0;
      case (state)
         IDLE: begin
            if (Clear) begin
               state_nxt = CLR;
               start_clr = 1'b1;
            end else if (Close) begin
               if (!closed) begin
                  state_nxt  = SCAN;
                  start_scan = 1'b1;
               end else begin
                  state_nxt = RESULT;
               end
            end else if (Ballot && !closed) begin
               state_nxt = ARMED;
            end else if (Total) begin
               state_nxt = TOTAL;
            end
         end
         ARMED: begin
            if (Clear) begin
               state_nxt = CLR;
               start_clr = 1'b1;
            end else if (in_valid) begin
               state_nxt = IDLE;
               vote      = 1'b1;
            end
         end
         TOTAL: begin
            if (Clear) begin
               state_nxt = CLR;
               start_clr = 1'b1;
            end else if (!Total) begin
               state_nxt = IDLE;
            end
         end
         SCAN: begin
            if (Clear) begin
               state_nxt = CLR;
               start_clr = 1'b1;
            end else if (scan_k == LAST) begin
               state_nxt = RESULT;
            end
         end
         RESULT: begin
            if (Clear) begin
               state_nxt = CLR;
               start_clr = 1'b1;
            end
         end
         CLR: begin
            if (clr_k == LAST) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      scan_val = '0;
      for (int k = 1; k <= N_CAND; k++) begin
         if (scan_k == IDX_W'(k)) scan_val = tally[k];
      end
   end

   assign scan_gt = scan_val > max_val;
   assign scan_eq = (scan_val == max_val) && (max_val != '0);
   assign win_fin = scan_gt ? scan_k : winner;

   // Display index follows the scan result, Result steps, and the clear sweep.
   always_comb begin
      out_idx_nxt = out_idx;
      if (state == SCAN && state_nxt == RESULT)
         out_idx_nxt = (win_fin == '0) ? FIRST : win_fin;
      else if (state == RESULT && state_nxt == RESULT && result_rise)
         out_idx_nxt = (out_idx == LAST) ? FIRST : out_idx + 1'b1;
      else if (state == CLR && clr_k == FIRST)
         out_idx_nxt = '0;
   end

   always_comb begin
      res_val = '0;
      for (int k = 1; k <= N_CAND; k++) begin
         if (out_idx_nxt == IDX_W'(k)) res_val = tally[k];
      end
   end

   always_comb begin
      case (state_nxt)
         TOTAL:   out_nxt = total;
         RESULT:  out_nxt = res_val;
         default: out_nxt = '0;
      endcase
   end

   always_ff @(posedge clk or negedge Power_n) begin
      if (!Power_n) begin
         for (int k = 1; k <= N_CAND; k++) tally[k] <= '0;
         total       <= '0;
         max_val     <= '0;
         closed      <= 1'b0;
         result_prev <= 1'b0;
         scan_k      <= '0;
         clr_k       <= '0;
         winner      <= '0;
         tie         <= 1'b0;
         win_valid   <= 1'b0;
         out_idx     <= '0;
         out         <= '0;
         reject      <= 1'b0;
      end else begin
         result_prev <= Result;
         reject      <= (state == ARMED) && !Clear && in_high;
         out_idx     <= out_idx_nxt;
         out         <= out_nxt;

         if (vote) begin
            for (int k = 1; k <= N_CAND; k++) begin
               if (IN == IDX_W'(k) && tally[k] != CNT_MAX) tally[k] <= tally[k] + 1'b1;
            end
            if (total != CNT_MAX) total <= total + 1'b1;
         end

         if (start_scan) begin
            closed    <= 1'b1;
            max_val   <= '0;
            winner    <= '0;
            tie       <= 1'b0;
            win_valid <= 1'b0;
            scan_k    <= FIRST;
         end

         if (state == SCAN && state_nxt != CLR) begin
            if (scan_gt) begin
               max_val <= scan_val;
               winner  <= scan_k;
               tie     <= 1'b0;
            end else if (scan_eq) begin
               tie <= 1'b1;
            end
            scan_k <= scan_k + 1'b1;
            if (state_nxt == RESULT) win_valid <= 1'b1;
         end

         if (start_clr) clr_k <= FIRST;

         // One tally per cycle; everything else is wiped on the first sweep cycle.
         if (state == CLR) begin
            for (int k = 1; k <= N_CAND; k++) begin
               if (clr_k == IDX_W'(k)) tally[k] <= '0;
            end
            clr_k <= clr_k + 1'b1;
            if (clr_k == FIRST) begin
               total     <= '0;
               max_val   <= '0;
               closed    <= 1'b0;
               win_valid <= 1'b0;
               tie       <= 1'b0;
               winner    <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_vote_tally_n.sv
// Directed bench: default instance plus N_CAND=10 and CNT_W=3 variants sharing a second input set.
module tb_vote_tally_n;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        power_n;
   logic        clear, close, ballot, total, result;
   logic [3:0]  in_code;
   logic [11:0] out;
   logic [3:0]  out_idx, winner;
   logic        ready, busy, reject, tie, win_valid;

   logic        clear_b, close_b, ballot_b, total_b, result_b;
   logic [3:0]  in_b;
   logic [11:0] out10;
   logic [3:0]  out_idx10, winner10;
   logic        ready10, busy10, reject10, tie10, win_valid10;
   logic [2:0]  out3;
   logic [3:0]  out_idx3, winner3;
   logic        ready3, busy3, reject3, tie3, win_valid3;

   int checks = 0;
   int errors = 0;

   vote_tally_n dut (
      .clk(clk), .Power_n(power_n), .Clear(clear), .Close(close), .Ballot(ballot),
      .Total(total), .Result(result), .IN(in_code), .out(out), .out_idx(out_idx),
      .ready(ready), .busy(busy), .reject(reject), .winner(winner), .tie(tie),
      .win_valid(win_valid)
   );

   vote_tally_n #(.N_CAND(10)) dut10 (
      .clk(clk), .Power_n(power_n), .Clear(clear_b), .Close(close_b), .Ballot(ballot_b),
      .Total(total_b), .Result(result_b), .IN(in_b), .out(out10), .out_idx(out_idx10),
      .ready(ready10), .busy(busy10), .reject(reject10), .winner(winner10), .tie(tie10),
      .win_valid(win_valid10)
   );

   vote_tally_n #(.CNT_W(3)) dut3 (
      .clk(clk), .Power_n(power_n), .Clear(clear_b), .Close(close_b), .Ballot(ballot_b),
      .Total(total_b), .Result(result_b), .IN(in_b), .out(out3), .out_idx(out_idx3),
      .ready(ready3), .busy(busy3), .reject(reject3), .winner(winner3), .tie(tie3),
      .win_valid(win_valid3)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Arm a ballot, then key in a candidate code on the following cycle.
   task automatic applyStimulus(input int cand, input bit on_b);
      if (!on_b) begin
         ballot = 1'b1; tick(1); ballot = 1'b0;
         in_code = 4'(cand); tick(1); in_code = '0;
      end else begin
         ballot_b = 1'b1; tick(1); ballot_b = 1'b0;
         in_b = 4'(cand); tick(1); in_b = '0;
      end
   endtask

   task automatic stepResult(input bit on_b);
      if (!on_b) begin
         result = 1'b1; tick(1); result = 1'b0; tick(1);
      end else begin
         result_b = 1'b1; tick(1); result_b = 1'b0; tick(1);
      end
   endtask

   initial begin
      power_n = 1'b1;
      {clear, close, ballot, total, result} = '0;
      {clear_b, close_b, ballot_b, total_b, result_b} = '0;
      in_code = '0;
      in_b    = '0;
      #2 power_n = 1'b0;
      tick(2);
      checkOutput("rst_out", out, 0);
      checkOutput("rst_out_idx", out_idx, 0);
      checkOutput("rst_ready", ready, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_reject", reject, 0);
      checkOutput("rst_winner", winner, 0);
      checkOutput("rst_tie", tie, 0);
      checkOutput("rst_win_valid", win_valid, 0);
      power_n = 1'b1;
      tick(1);

      $display("[TB] votes and total");
      applyStimulus(3, 0);
      applyStimulus(3, 0);
      applyStimulus(7, 0);
      total = 1'b1; tick(1);
      checkOutput("total_three", out, 3);
      checkOutput("total_not_ready", ready, 0);
      total = 1'b0; tick(1);
      checkOutput("idle_out_zero", out, 0);

      $display("[TB] clear sweep");
      clear = 1'b1; tick(1); clear = 1'b0;
      checkOutput("clr_busy_first", busy, 1);
      tick(14);
      checkOutput("clr_busy_last", busy, 1);
      tick(1);
      checkOutput("clr_done", busy, 0);
      total = 1'b1; tick(1);
      checkOutput("clr_total_zero", out, 0);
      total = 1'b0; tick(1);

      $display("[TB] winner and tie");
      repeat (4) applyStimulus(2, 0);
      repeat (4) applyStimulus(5, 0);
      applyStimulus(9, 0);
      close = 1'b1; tick(1); close = 1'b0;
      checkOutput("scan_busy_first", busy, 1);
      tick(14);
      checkOutput("scan_busy_last", busy, 1);
      checkOutput("scan_no_valid", win_valid, 0);
      tick(1);
      checkOutput("scan_done", busy, 0);
      checkOutput("win_valid", win_valid, 1);
      checkOutput("winner_two", winner, 2);
      checkOutput("tie_set", tie, 1);
      checkOutput("res_idx_two", out_idx, 2);
      checkOutput("res_out_four", out, 4);

      ballot = 1'b1; tick(1); ballot = 1'b0;
      checkOutput("closed_no_arm", ready, 0);
      checkOutput("closed_out_same", out, 4);

      $display("[TB] result stepping");
      stepResult(0);
      checkOutput("step_idx3", out_idx, 3);
      checkOutput("step_out3", out, 0);
      stepResult(0);
      stepResult(0);
      checkOutput("step_idx5", out_idx, 5);
      checkOutput("step_out5", out, 4);
      repeat (10) stepResult(0);
      checkOutput("step_idx15", out_idx, 15);
      stepResult(0);
      checkOutput("step_wrap_idx", out_idx, 1);
      checkOutput("step_wrap_out", out, 0);
      result = 1'b1; tick(10); result = 1'b0; tick(1);
      checkOutput("held_one_step", out_idx, 2);
      checkOutput("held_out", out, 4);

      $display("[TB] clear from result");
      clear = 1'b1; tick(1); clear = 1'b0;
      tick(15);
      checkOutput("rclr_busy", busy, 0);
      checkOutput("rclr_win_valid", win_valid, 0);
      checkOutput("rclr_winner", winner, 0);
      checkOutput("rclr_tie", tie, 0);
      checkOutput("rclr_out_idx", out_idx, 0);

      $display("[TB] zero code and last candidate");
      ballot = 1'b1; tick(1); ballot = 1'b0;
      in_code = 4'd0; tick(1);
      checkOutput("zero_stay_armed", ready, 1);
      checkOutput("zero_no_reject", reject, 0);
      in_code = 4'd15; tick(1); in_code = '0;
      checkOutput("fifteen_taken", ready, 0);

      $display("[TB] clear during scan");
      close = 1'b1; tick(1); close = 1'b0;
      tick(4);
      clear = 1'b1; tick(1); clear = 1'b0;
      checkOutput("abort_busy", busy, 1);
      checkOutput("abort_win_valid", win_valid, 0);
      tick(14);
      checkOutput("abort_busy_last", busy, 1);
      tick(1);
      checkOutput("abort_done", busy, 0);
      checkOutput("abort_win_valid_end", win_valid, 0);
      ballot = 1'b1; tick(1); ballot = 1'b0;
      checkOutput("reopened_armed", ready, 1);
      in_code = 4'd6; tick(1); in_code = '0;

      $display("[TB] reset while armed");
      ballot = 1'b1; tick(1); ballot = 1'b0;
      checkOutput("pre_rst_armed", ready, 1);
      power_n = 1'b0;
      #1;
      checkOutput("async_ready", ready, 0);
      checkOutput("async_busy", busy, 0);
      checkOutput("async_out", out, 0);
      tick(1);
      power_n = 1'b1;
      tick(1);
      total = 1'b1; tick(1);
      checkOutput("post_rst_total", out, 0);
      total = 1'b0; tick(1);
      close = 1'b1; tick(1); close = 1'b0;
      tick(15);
      checkOutput("zero_win_valid", win_valid, 1);
      checkOutput("zero_winner", winner, 0);
      checkOutput("zero_tie", tie, 0);
      checkOutput("zero_out_idx", out_idx, 1);
      checkOutput("zero_out", out, 0);

      $display("[TB] N_CAND=10 and CNT_W=3 variants");
      ballot_b = 1'b1; tick(1); ballot_b = 1'b0;
      in_b = 4'd12; tick(1);
      checkOutput("n10_reject", reject10, 1);
      checkOutput("n10_stay_armed", ready10, 1);
      in_b = 4'd4; tick(1); in_b = '0;
      checkOutput("n10_reject_end", reject10, 0);
      checkOutput("n10_taken", ready10, 0);
      repeat (9) applyStimulus(1, 1);
      total_b = 1'b1; tick(1);
      checkOutput("n10_total", out10, 10);
      checkOutput("sat_total", out3, 7);
      total_b = 1'b0; tick(1);
      close_b = 1'b1; tick(1); close_b = 1'b0;
      tick(9);
      checkOutput("n10_scan_busy", busy10, 1);
      tick(1);
      checkOutput("n10_win_valid", win_valid10, 1);
      checkOutput("n10_winner", winner10, 1);
      checkOutput("n10_tie", tie10, 0);
      checkOutput("n10_out", out10, 9);
      tick(5);
      checkOutput("sat_winner", winner3, 1);
      checkOutput("sat_tie", tie3, 0);
      checkOutput("sat_tally", out3, 7);
      repeat (3) stepResult(1);
      checkOutput("n10_idx4", out_idx10, 4);
      checkOutput("n10_out4", out10, 1);
      repeat (6) stepResult(1);
      checkOutput("n10_idx10", out_idx10, 10);
      stepResult(1);
      checkOutput("n10_wrap_idx", out_idx10, 1);
      checkOutput("n10_wrap_out", out10, 9);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
